// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit owning HI/LO with fixed-latency countdown
// Optional feature macro: MDU_MADD_EN (enables madd/maddu accumulate ops 9/10).
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif
  localparam logic [3:0] LAT_MUL  = 4'd5;
  localparam logic [3:0] LAT_DIV  = 4'd10;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        idle, commit, accept_start;
  logic [31:0] cur_hi, cur_lo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign idle         = (cnt_q == 4'd0);
  assign commit       = (cnt_q == 4'd1);
  assign accept_start = idle | commit;

  // A start at the commit edge must see the values being committed, not the stale HI/LO.
  assign cur_hi = commit ? hi_p_q : hi_q;
  assign cur_lo = commit ? lo_p_q : lo_q;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = A / B;
  assign r_u   = A % B;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_p_d = hi_p_q;
    lo_p_d = lo_p_q;
    cnt_d  = cnt_q;

    if (!idle) cnt_d = cnt_q - 4'd1;
    if (commit) begin
      hi_d = hi_p_q;
      lo_d = lo_p_q;
    end

    if (accept_start) begin
      case (MDUOp)
        OP_MULT:  begin {hi_p_d, lo_p_d} = prod_s; cnt_d = LAT_MUL; end
        OP_MULTU: begin {hi_p_d, lo_p_d} = prod_u; cnt_d = LAT_MUL; end
        // Divide by zero re-commits the current values, leaving HI/LO unchanged.
        OP_DIV: begin
          {hi_p_d, lo_p_d} = (B != 32'd0) ? {r_s, q_s} : {cur_hi, cur_lo};
          cnt_d = LAT_DIV;
        end
        OP_DIVU: begin
          {hi_p_d, lo_p_d} = (B != 32'd0) ? {r_u, q_u} : {cur_hi, cur_lo};
          cnt_d = LAT_DIV;
        end
`ifdef MDU_MADD_EN
        OP_MADD:  begin {hi_p_d, lo_p_d} = {cur_hi, cur_lo} + prod_s; cnt_d = LAT_MUL; end
        OP_MADDU: begin {hi_p_d, lo_p_d} = {cur_hi, cur_lo} + prod_u; cnt_d = LAT_MUL; end
`endif
        default: ;
      endcase
    end

    if (idle) begin
      case (MDUOp)
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_p_q <= 32'd0;
      lo_p_q <= 32'd0;
      cnt_q  <= 4'd0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_p_q <= hi_p_d;
      lo_p_q <= lo_p_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = ~idle;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUOut = 32'd0;
    case (MDUOp)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed and random checks of e_mdu against a cycle-indexed reference model
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  MDUOp = 4'd0;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
    .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  // Reference: architectural HI/LO plus one pending result tagged with its commit edge number.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_v = 1'b0;
  int          edge_n = 0, commit_at = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic rst_n);
    logic [63:0] acc, ua, ub, tq, tr;
    longint sa, sb;
    bit was_busy;
    int lat;
    edge_n++;
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_v = 0;
      return;
    end
    was_busy = p_v;
    if (p_v && edge_n == commit_at) begin
      m_hi = p_hi; m_lo = p_lo; p_v = 0;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {m_hi, m_lo};
    lat = 0;
    case (op)
      4'd1: begin acc = sa * sb; lat = 5; end
      4'd2: begin acc = ua * ub; lat = 5; end
      4'd3: begin
        lat = 10;
        if (b != 0) begin tq = sa / sb; tr = sa % sb; acc = {tr[31:0], tq[31:0]}; end
      end
      4'd4: begin
        lat = 10;
        if (b != 0) acc = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      4'd9:  begin acc = acc + sa * sb; lat = 5; end
      4'd10: begin acc = acc + ua * ub; lat = 5; end
`endif
      default: ;
    endcase
    if (lat != 0 && !p_v) begin
      p_v = 1; {p_hi, p_lo} = acc; commit_at = edge_n + lat;
    end
    if (!was_busy) begin
      if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rst_n = 1'b1);
    reset = rst_n; MDUOp = op; A = a; B = b;
    #1;
    chk("mduout", MDUOut, (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0);
    @(posedge clk);
    model_edge(op, a, b, rst_n);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, p_v});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  initial begin
    int bc;
    logic [3:0] op;
    logic [31:0] ra, rb;

    step(4'd0, 0, 0, 1'b0);
    step(4'd0, 0, 0, 1'b0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    bc = 0; step(4'd1, 32'hFFFFFFFE, 32'd3); bc += busy;
    repeat (5) begin step(4'd0, 0, 0); bc += busy; end
    chk("mult_busy_cycles", bc, 5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    step(4'd2, 32'hFFFFFFFE, 32'd3);
    repeat (5) step(4'd0, 0, 0);
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    bc = 0; step(4'd3, 32'hFFFFFFF9, 32'd2); bc += busy;
    repeat (10) begin step(4'd0, 0, 0); bc += busy; end
    chk("div_busy_cycles", bc, 10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    bc = 0; step(4'd4, 32'd7, 32'd0); bc += busy;
    repeat (10) begin step(4'd0, 0, 0); bc += busy; end
    chk("div0_busy_cycles", bc, 10);
    chk("div0_hi", HI, 32'hFFFFFFFF);
    chk("div0_lo", LO, 32'hFFFFFFFD);

    step(4'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (10) step(4'd0, 0, 0);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'd0);

    step(4'd7, 32'h12345678, 0);
    MDUOp = 4'd5; #1;
    chk("mfhi_after_mthi", MDUOut, 32'h12345678);

    step(4'd8, 32'hAAAA5555, 0);
    step(4'd4, 32'd256, 32'd7);
    step(4'd8, 32'hDEADBEEF, 0);
    repeat (10) step(4'd0, 0, 0);
    chk("mtlo_busy_lo", LO, 32'd36);
    chk("mtlo_busy_hi", HI, 32'd4);

    step(4'd1, 32'd5, 32'd6);
    step(4'd3, 32'd9, 32'd2);
    step(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) step(4'd0, 0, 0);
    chk("ignored_start_hi", HI, 32'd0);
    chk("ignored_start_lo", LO, 32'd30);

    bc = 0; step(4'd1, 32'd7, 32'd8); bc += busy;
    repeat (4) begin step(4'd0, 0, 0); bc += busy; end
    step(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); bc += busy;
    chk("b2b_first_commit", LO, 32'd56);
    repeat (5) begin step(4'd0, 0, 0); bc += busy; end
    chk("b2b_busy_cycles", bc, 10);
    chk("b2b_hi", HI, 32'd0);
    chk("b2b_lo", LO, 32'd1);

    step(4'd3, 32'd100, 32'd3);
    repeat (4) step(4'd0, 0, 0);
    step(4'd0, 0, 0, 1'b0);
    step(4'd0, 0, 0, 1'b0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (10) step(4'd0, 0, 0);
    chk("midrst_nocommit_lo", LO, 32'd0);

`ifdef MDU_MADD_EN
    step(4'd7, 32'd0, 0);
    step(4'd8, 32'hFFFFFFFF, 0);
    step(4'd10, 32'd1, 32'd1);
    repeat (5) step(4'd0, 0, 0);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
`else
    step(4'd8, 32'h0BADF00D, 0);
    step(4'd9, 32'd3, 32'd4);
    chk("op9_busy", {31'd0, busy}, 32'd0);
    chk("op9_lo", LO, 32'h0BADF00D);
`endif

    repeat (400) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      step(op, ra, rb, ($urandom_range(0, 59) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
